// File: rtl/gfx_wc_pkg.sv
// gfx_wc_pkg: shared types and pixel-size helpers for the pixel write combiner
package gfx_wc_pkg;
  typedef enum logic [1:0] {D8 = 2'd0, D16 = 2'd1, D32 = 2'd3} depth_e;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;
  function automatic logic [3:0] depth_sel(input logic [1:0] d);
    return d == D8 ? 4'h1 : d == D16 ? 4'h3 : d == D32 ? 4'hF : 4'h0;
  endfunction
  function automatic logic [31:0] depth_mask(input logic [1:0] d);
    return d == D8 ? 32'h0000_00FF : d == D16 ? 32'h0000_FFFF : d == D32 ? 32'hFFFF_FFFF : 32'h0;
  endfunction
  function automatic logic [1:0] depth_align(input logic [1:0] d);
    return d == D16 ? 2'b01 : d == D32 ? 2'b11 : 2'b00;
  endfunction
endpackage

// File: rtl/gfx_pixel_lane_align.sv
// gfx_pixel_lane_align: places one pixel colour into its byte lanes of a memory word
module gfx_pixel_lane_align
  import gfx_wc_pkg::*;
#(
  parameter int MEM_W = 128,
  localparam int LANES = MEM_W / 8,
  localparam int OFF_W = $clog2(LANES)
) (
  input  logic [1:0]       i_depth,
  input  logic [31:0]      i_color,
  input  logic [OFF_W-1:0] i_offset,
  output logic [MEM_W-1:0] o_data,
  output logic [LANES-1:0] o_sel
);
  logic [OFF_W-1:0] w_off;
  assign w_off  = i_offset & ~OFF_W'(depth_align(i_depth));
  assign o_sel  = LANES'(depth_sel(i_depth)) << w_off;
  assign o_data = MEM_W'(i_color & depth_mask(i_depth)) << {w_off, 3'b000};
endmodule

// File: rtl/gfx_pixel_write_combiner.sv
// gfx_pixel_write_combiner: merges pixel writes into masked memory line writes
module gfx_pixel_write_combiner
  import gfx_wc_pkg::*;
#(
  parameter int MEM_W = 128,
  parameter int ADDR_W = 32,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           color_depth_i,
  input  logic                 pix_valid_i,
  output logic                 pix_ready_o,
  input  logic [ADDR_W-1:0]    pix_addr_i,
  input  logic [31:0]          pix_color_i,
  input  logic                 flush_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [MEM_W-1:0]     mem_data_o,
  output logic [MEM_W/8-1:0]   mem_sel_o,
  output logic                 busy_o
);
  localparam int LANES = MEM_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int CNT_W = FLUSH_TIMEOUT > 0 ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLUSH_TIMEOUT);
  state_e            r_state, w_state_nxt;
  logic [LINE_W-1:0] r_line, w_line;
  logic [MEM_W-1:0]  r_data, w_data_new, w_bmask, w_data_nxt;
  logic [LANES-1:0]  r_sel, w_sel_new, w_sel_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_hit, w_acc, w_wr, w_fire;
  assign w_line      = pix_addr_i[ADDR_W-1:OFF_W];
  assign w_hit       = w_line == r_line;
  assign pix_ready_o = r_state == IDLE || (r_state == FILL && w_hit && !flush_i);
  assign w_acc       = pix_valid_i && pix_ready_o;
  assign w_wr        = w_acc && |w_sel_new;
  gfx_pixel_lane_align #(.MEM_W(MEM_W)) u_align (
    .i_depth (color_depth_i),
    .i_color (pix_color_i),
    .i_offset(pix_addr_i[OFF_W-1:0]),
    .o_data  (w_data_new),
    .o_sel   (w_sel_new)
  );
  // expand the new pixel's byte selects into a bit mask so later writes overwrite earlier bytes
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < LANES; i++) w_bmask[8*i +: 8] = {8{w_sel_new[i]}};
  end
  assign w_data_nxt = w_wr ? (r_data & ~w_bmask) | w_data_new : r_data;
  assign w_sel_nxt  = r_sel | (w_wr ? w_sel_new : '0);
  assign w_cnt_nxt  = (r_state == FILL && !w_wr) ? (r_cnt == CNT_MAX ? r_cnt : r_cnt + 1'b1) : '0;
  assign w_fire     = &w_sel_nxt || flush_i || (pix_valid_i && !w_hit) ||
                      (FLUSH_TIMEOUT != 0 && w_cnt_nxt == CNT_MAX);
  // next state: fill on first real pixel, drain on full/flush/miss/timeout, idle once memory takes the line
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE && w_wr) w_state_nxt = FILL;
    else if (r_state == FILL && w_fire) w_state_nxt = DRAIN;
    else if (r_state == DRAIN && mem_ready_i) w_state_nxt = IDLE;
  end
  // state, line buffer and idle counter; buffer contents are frozen while draining
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_data  <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= (r_state == DRAIN && mem_ready_i) ? '0 : w_sel_nxt;
      r_line  <= (r_state == IDLE && w_wr) ? w_line : r_line;
    end
  end
  assign mem_valid_o = r_state == DRAIN;
  assign busy_o      = r_state != IDLE;
  assign mem_addr_o  = {r_line, {OFF_W{1'b0}}};
  assign mem_data_o  = r_data;
  assign mem_sel_o   = r_sel;
endmodule

// File: tb/tb_gfx_pixel_write_combiner.sv
// tb_gfx_pixel_write_combiner: directed stimulus against a byte-level behavioural model
module tb_gfx_pixel_write_combiner;
  localparam int TO = 16;
  logic clk = 0, rst_ni = 0;
  logic [1:0] depth = 0;
  logic pix_valid = 0, flush = 0, mem_ready = 0, nt_valid = 0;
  logic [31:0] pix_addr = 0, pix_color = 0;
  logic pix_ready_o, mem_valid_o, busy_o;
  logic [31:0] mem_addr_o;
  logic [127:0] mem_data_o;
  logic [15:0] mem_sel_o;
  logic nt_ready, nt_mv, nt_busy;
  logic [31:0] nt_maddr;
  logic [127:0] nt_mdata;
  logic [15:0] nt_msel;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  gfx_pixel_write_combiner #(.MEM_W(128), .ADDR_W(32), .FLUSH_TIMEOUT(TO)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .color_depth_i(depth), .pix_valid_i(pix_valid),
    .pix_ready_o(pix_ready_o), .pix_addr_i(pix_addr), .pix_color_i(pix_color), .flush_i(flush),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o), .busy_o(busy_o));

  gfx_pixel_write_combiner #(.MEM_W(128), .ADDR_W(32), .FLUSH_TIMEOUT(0)) u_nt (
    .clk_i(clk), .rst_ni(rst_ni), .color_depth_i(depth), .pix_valid_i(nt_valid),
    .pix_ready_o(nt_ready), .pix_addr_i(pix_addr), .pix_color_i(pix_color), .flush_i(1'b0),
    .mem_valid_o(nt_mv), .mem_ready_i(1'b0), .mem_addr_o(nt_maddr),
    .mem_data_o(nt_mdata), .mem_sel_o(nt_msel), .busy_o(nt_busy));

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [127:0] bmask(input logic [15:0] s);
    logic [127:0] m = '0;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // behavioural model: a 16-byte line with per-byte written flags
  bit m_busy, m_drain;
  logic [31:0] m_line;
  logic [7:0] m_b[16];
  bit m_en[16];
  int m_cnt;

  function automatic bit m_ready();
    return !m_busy || (!m_drain && (pix_addr >> 4) == m_line && !flush);
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 0; m_drain = 0; m_cnt = 0; m_line = 0;
      for (int i = 0; i < 16; i++) m_en[i] = 0;
    end else if (m_drain) begin
      if (mem_ready) begin
        m_busy = 0; m_drain = 0;
        for (int i = 0; i < 16; i++) m_en[i] = 0;
      end
    end else begin
      bit acc, was_fill, wrote, all;
      int size, off;
      acc = pix_valid && m_ready();
      was_fill = m_busy;
      wrote = acc && depth != 2'd2;
      if (wrote) begin
        size = depth == 2'd0 ? 1 : depth == 2'd1 ? 2 : 4;
        off = pix_addr % 16;
        off = off - off % size;
        for (int k = 0; k < size; k++) begin
          m_b[off+k] = pix_color[8*k +: 8];
          m_en[off+k] = 1;
        end
        if (!m_busy) m_line = pix_addr >> 4;
        m_busy = 1;
      end
      m_cnt = (was_fill && !wrote) ? (m_cnt < TO ? m_cnt + 1 : TO) : 0;
      if (was_fill) begin
        all = 1;
        for (int i = 0; i < 16; i++) all &= m_en[i];
        if (all || flush || (pix_valid && (pix_addr >> 4) != m_line) || (TO != 0 && m_cnt == TO))
          m_drain = 1;
      end
    end
  end

  // every cycle out of reset: handshake/status always, line contents while a write is offered
  logic [15:0] es;
  logic [127:0] ed;
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("ready", pix_ready_o, m_ready());
      chk("busy", busy_o, m_busy);
      chk("mem_valid", mem_valid_o, m_drain);
      if (m_drain) begin
        for (int i = 0; i < 16; i++) begin
          es[i] = m_en[i];
          ed[8*i +: 8] = m_b[i];
        end
        chk("mem_addr", mem_addr_o, m_line << 4);
        chk("mem_sel", mem_sel_o, es);
        chk("mem_data", mem_data_o & bmask(es), ed & bmask(es));
      end
    end
  end

  typedef struct {logic [31:0] a; logic [15:0] s; logic [127:0] d;} wr_t;
  wr_t wr_q[$];
  int wi = 0;
  always @(posedge clk)
    if (rst_ni && mem_valid_o && mem_ready) wr_q.push_back('{mem_addr_o, mem_sel_o, mem_data_o});

  task automatic expect_wr(input string nm, input logic [31:0] a, input logic [15:0] s, input logic [127:0] d);
    if (wr_q.size() <= wi) begin
      chk({nm, "_count"}, 128'(wr_q.size()), 128'(wi + 1));
    end else begin
      chk({nm, "_addr"}, wr_q[wi].a, a);
      chk({nm, "_sel"}, wr_q[wi].s, s);
      chk({nm, "_data"}, wr_q[wi].d & bmask(s), d & bmask(s));
      wi++;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] c, input logic [1:0] d, output int n);
    pix_valid = 1; pix_addr = a; pix_color = c; depth = d; n = 0;
    while (1) begin
      @(negedge clk);
      if (pix_ready_o) break;
      n++;
      if (n > 50) begin chk("send_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    pix_valid = 0;
  endtask

  task automatic flush_pulse();
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
  endtask

  task automatic drain();
    int n = 0;
    mem_ready = 1;
    while (1) begin
      @(negedge clk);
      if (mem_valid_o) break;
      n++;
      if (n > 40) begin chk("drain_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    mem_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    logic [127:0] d;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_mem_sel", mem_sel_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1;
    @(negedge clk);
    chk("rst_ready", pix_ready_o, 1);
    @(posedge clk); #1;

    // full line of 8bpp pixels back to back
    d = '0;
    for (int i = 0; i < 16; i++) begin
      send(32'h100 + i, 32'hAA + i, 2'd0, n);
      chk("burst_ready", n, 0);
      d[8*i +: 8] = 8'hAA + i;
    end
    drain();
    expect_wr("burst", 32'h100, 16'hFFFF, d);
    chk("burst_one_write", wr_q.size(), 1);

    // 32bpp then overlapping 16bpp, later write wins
    send(32'h204, 32'h11223344, 2'd3, n);
    send(32'h206, 32'h0000BEEF, 2'd1, n);
    flush_pulse();
    drain();
    expect_wr("merge", 32'h200, 16'h00F0, 128'hBEEF3344 << 32);

    // line miss with memory back-pressure
    send(32'h300, 32'h0000CAFE, 2'd1, n);
    pix_valid = 1; pix_addr = 32'h310; pix_color = 32'h1234; depth = 2'd1;
    @(negedge clk);
    chk("miss_ready", pix_ready_o, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", mem_valid_o, 1);
      chk("stall_addr", mem_addr_o, 32'h300);
      chk("stall_sel", mem_sel_o, 16'h0003);
      chk("stall_data", mem_data_o[15:0], 16'hCAFE);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(negedge clk);
    chk("miss_ready_drain", pix_ready_o, 0);
    @(posedge clk); #1;
    mem_ready = 0;
    @(negedge clk);
    chk("miss_accept_next", pix_ready_o, 1);
    @(posedge clk); #1;
    pix_valid = 0;
    expect_wr("miss_first", 32'h300, 16'h0003, 128'hCAFE);
    flush_pulse();
    drain();
    expect_wr("miss_second", 32'h310, 16'h0003, 128'h1234);

    // idle timeout
    send(32'h40F, 32'h5A, 2'd0, n);
    k = 0;
    while (!mem_valid_o && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("timeout_latency", k, 16);
    drain();
    expect_wr("timeout", 32'h400, 16'h8000, 128'h5A << 120);

    // misaligned 32bpp and reserved depth
    send(32'h503, 32'hDEADBEEF, 2'd3, n);
    flush_pulse();
    drain();
    expect_wr("misaligned", 32'h500, 16'h000F, 128'hDEADBEEF);
    k = wr_q.size();
    send(32'h700, 32'h55, 2'd2, n);
    chk("rsv_accepted", n, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rsv_busy", busy_o, 0);
    chk("rsv_no_write", wr_q.size(), k);

    // reset while draining with memory stalled
    send(32'h600, 32'h01020304, 2'd3, n);
    flush_pulse();
    @(negedge clk);
    chk("pre_rst_valid", mem_valid_o, 1);
    #2 rst_ni = 0;
    #1;
    chk("rst_drain_valid", mem_valid_o, 0);
    chk("rst_drain_busy", busy_o, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1;
    mem_ready = 1;
    k = wr_q.size();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_write", wr_q.size(), k);
    chk("rst_after_valid", mem_valid_o, 0);
    mem_ready = 0;

    // timeout disabled instance holds its line
    pix_addr = 32'h40F; pix_color = 32'h77; depth = 2'd0;
    nt_valid = 1;
    @(negedge clk);
    chk("nt_ready", nt_ready, 1);
    @(posedge clk); #1;
    nt_valid = 0;
    repeat (60) @(posedge clk);
    #1;
    chk("nt_hold_valid", nt_mv, 0);
    chk("nt_hold_busy", nt_busy, 1);
    chk("nt_hold_sel", nt_msel, 16'h8000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
